// File: rtl/wb_dma_periph_fifo_if.sv
// 32-bit Wishbone classic bus bundle shared by the DMA master and its
// slave-side peripherals.
interface wb_if;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic [31:0] DAT_R;
    logic [3:0]  SEL;
    logic        WE;
    logic        CYC;
    logic        STB;
    logic        ACK;
    logic        ERR;

    modport slave (
        input  ADR, DAT_W, SEL, WE, CYC, STB,
        output DAT_R, ACK, ERR
    );

    modport master (
        output ADR, DAT_W, SEL, WE, CYC, STB,
        input  DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_dma_periph_fifo.sv
// Wishbone slave transmit FIFO filled by a DMA channel through a req/ack
// handshake and drained to a first-word-fall-through valid/ready stream.
module wb_dma_periph_fifo #(
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        rst_i,
    wb_if.slave         wbs,
    output logic        dma_req_o,
    input  logic        dma_ack_i,
    output logic        dout_valid,
    output logic [31:0] dout_data,
    input  logic        dout_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] BURST_L = LW'(BURST);
    localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          enable_r;
    logic          ovf_r;
    logic          ack_r;
    logic          err_r;
    logic [31:0]   dat_r_r;
    logic          req_r;
    state_t        state_r;
    state_t        state_next_s;

    logic          resp_s;
    logic          full_s;
    logic          empty_s;
    logic          data_wr_s;
    logic          ctrl_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic [LW-1:0] free_s;
    logic [31:0]   status_s;
    logic [31:0]   rdata_s;

    // Address bits and byte lanes that the register map never decodes.
    wire unused_s = ^{wbs.SEL, wbs.ADR[31:4], wbs.ADR[1:0]};

    // Bus decode, FIFO strobes and the STATUS word.
    always_comb begin
        resp_s    = wbs.CYC & wbs.STB & ~ack_r & ~err_r;
        full_s    = (level_r == DEPTH_L);
        empty_s   = (level_r == {LW{1'b0}});
        data_wr_s = resp_s & wbs.WE & (wbs.ADR[3:2] == A_DATA);
        ctrl_wr_s = resp_s & wbs.WE & (wbs.ADR[3:2] == A_CTRL);
        push_s    = data_wr_s & ~full_s;
        ovf_set_s = data_wr_s & full_s;
        flush_s   = ctrl_wr_s & wbs.DAT_W[2];
        ovf_clr_s = ctrl_wr_s & wbs.DAT_W[1];
        pop_s     = ~empty_s & dout_ready;
        free_s    = DEPTH_L - level_r;

        status_s       = 32'd0;
        status_s[8:0]  = 9'(level_r);
        status_s[16]   = full_s;
        status_s[17]   = empty_s;
        status_s[18]   = ovf_r;
        status_s[19]   = req_r;
    end

    // Read-data mux; DATA and the reserved slot read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (wbs.ADR[3:2])
            A_STATUS: rdata_s = status_s;
            A_CTRL:   rdata_s = {31'd0, enable_r};
            default:  rdata_s = 32'd0;
        endcase
    end

    // Single-cycle ACK/ERR pulse; ERR only for a DATA write into a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_r_r <= 32'd0;
        end else begin
            ack_r   <= resp_s & ~ovf_set_s;
            err_r   <= ovf_set_s;
            dat_r_r <= (resp_s & ~wbs.WE) ? rdata_s : 32'd0;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wbs.DAT_W;
        end
    end

    // Pointers and level; flush overrides a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst_i || flush_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // CTRL enable and overflow sticky; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            enable_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= wbs.DAT_W[0];
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Request FSM next state; once raised, a request is held until acknowledged.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_r && (free_s >= BURST_L)) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dma_ack_i) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_GAP:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with the request output registered alongside it.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            req_r   <= (state_next_s == ST_REQ);
        end
    end

    assign wbs.ACK    = ack_r;
    assign wbs.ERR    = err_r;
    assign wbs.DAT_R  = dat_r_r;
    assign dma_req_o  = req_r;
    assign dout_valid = ~empty_s;
    assign dout_data  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_wb_dma_periph_fifo.sv
// Directed bench for wb_dma_periph_fifo (DEPTH=16, BURST=4): bus handshake,
// request FSM timing, overflow, wrap ordering, flush and reset.
module tb_wb_dma_periph_fifo;

    logic        clk;
    logic        rst_i;
    logic        dma_req_o;
    logic        dma_ack_i;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic        dout_ready;

    int n_checks;
    int n_fail;

    logic        mon_en;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    wb_if bus();

    wb_dma_periph_fifo #(.DEPTH(16), .BURST(4)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .wbs        (bus),
        .dma_req_o  (dma_req_o),
        .dma_ack_i  (dma_ack_i),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_ready (dout_ready)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record every word the stream sink accepts.
    always @(negedge clk) begin
        if (mon_en && dout_valid && dout_ready) begin
            got_q.push_back(dout_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic [3:0] adr, input logic we, input logic [31:0] wdat,
                             input logic rdy, output logic [31:0] rdat, output logic ack,
                             output logic err, output int lat);
        @(posedge clk);
        #2;
        bus.ADR   = {28'd0, adr};
        bus.WE    = we;
        bus.DAT_W = wdat;
        bus.SEL   = 4'hF;
        bus.CYC   = 1'b1;
        bus.STB   = 1'b1;
        dout_ready = rdy;
        lat  = 0;
        ack  = 1'b0;
        err  = 1'b0;
        rdat = 32'd0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (bus.ACK || bus.ERR) begin
                lat  = n;
                ack  = bus.ACK;
                err  = bus.ERR;
                rdat = bus.DAT_R;
                break;
            end
        end
        check("wb_resp_seen", {31'd0, (ack | err)}, 32'd1);
        #1;
        bus.CYC = 1'b0;
        bus.STB = 1'b0;
        bus.WE  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wdat, input logic rdy);
        logic [31:0] rd;
        logic        a;
        logic        e;
        int          l;
        wb_access(adr, 1'b1, wdat, rdy, rd, a, e, l);
        check("wr_ack", {30'd0, a, e}, 32'd2);
    endtask

    task automatic wb_read(input logic [3:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        a;
        logic        e;
        int          l;
        wb_access(adr, 1'b0, 32'd0, dout_ready, rd, a, e, l);
        check(tag, rd, exp);
    endtask

    // Ack pulse sampled at edge A; dma_req_o is checked low right after A.
    task automatic dma_pulse();
        @(posedge clk);
        #2;
        dma_ack_i = 1'b1;
        @(posedge clk);
        #1;
        check("req_low_after_ack", {31'd0, dma_req_o}, 32'd0);
        #1;
        dma_ack_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        a;
        logic        e;
        int          l;

        clk        = 1'b0;
        rst_i      = 1'b1;
        dma_ack_i  = 1'b0;
        dout_ready = 1'b0;
        mon_en     = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        bus.ADR    = 32'd0;
        bus.DAT_W  = 32'd0;
        bus.SEL    = 4'h0;
        bus.WE     = 1'b0;
        bus.CYC    = 1'b0;
        bus.STB    = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        rst_i = 1'b0;

        // Reset state and first STATUS read.
        check("rst_req",   {31'd0, dma_req_o},  32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_ack",   {30'd0, bus.ACK, bus.ERR}, 32'd0);
        check("rst_datr",  bus.DAT_R, 32'd0);
        wb_access(4'h4, 1'b0, 32'd0, 1'b0, rd, a, e, l);
        check("status_rst", rd, 32'h0002_0000);
        check("ack_latency", 32'(l), 32'd1);
        check("status_ack", {30'd0, a, e}, 32'd2);
        check("req_idle", {31'd0, dma_req_o}, 32'd0);

        // Enable: request rises on the second edge after the CTRL write.
        wb_write(4'h8, 32'd1, 1'b0);
        check("req_not_yet", {31'd0, dma_req_o}, 32'd0);
        @(posedge clk);
        #1;
        check("req_raised", {31'd0, dma_req_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wb_write(4'h0, 32'hA0 + 32'(i), 1'b0);
        end
        wb_read(4'h4, 32'h0008_0004, "status_lvl4");
        check("head_a0", dout_data, 32'h0000_00A0);
        check("valid_lvl4", {31'd0, dout_valid}, 32'd1);
        wb_read(4'h0, 32'd0, "data_reads_zero");
        wb_read(4'hC, 32'd0, "rsvd_reads_zero");
        wb_read(4'h8, 32'd1, "ctrl_readback");
        dma_pulse();
        @(posedge clk);
        #1;
        check("req_gap2", {31'd0, dma_req_o}, 32'd0);
        @(posedge clk);
        #1;
        check("req_rearm", {31'd0, dma_req_o}, 32'd1);

        // Fill to 16, overflow write, then clear the sticky.
        for (int i = 0; i < 12; i++) begin
            wb_write(4'h0, 32'hB0 + 32'(i), 1'b0);
        end
        wb_access(4'h0, 1'b1, 32'h0000_DEAD, 1'b0, rd, a, e, l);
        check("ovf_err", {30'd0, a, e}, 32'd1);
        wb_read(4'h4, 32'h000D_0010, "status_ovf");
        wb_write(4'hC, 32'hFFFF_FFFF, 1'b0);
        wb_write(4'h8, 32'd3, 1'b0);
        wb_read(4'h4, 32'h0009_0010, "status_ovf_clr");
        wb_read(4'h8, 32'd1, "ctrl_selfclear");
        check("head_kept", dout_data, 32'h0000_00A0);

        // Flush while in REQ keeps the request; then ordering across wrap.
        wb_write(4'h8, 32'd5, 1'b0);
        wb_read(4'h4, 32'h000A_0000, "status_flushed");
        for (int i = 0; i < 13; i++) begin
            wb_write(4'h0, 32'h100 + 32'(i), 1'b0);
            exp_q.push_back(32'h100 + 32'(i));
        end
        mon_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wb_write(4'h0, 32'(k), 1'b1);
            exp_q.push_back(32'(k));
        end
        for (int n = 0; n < 80; n++) begin
            if (!dout_valid) break;
            @(negedge clk);
        end
        check("drained", {31'd0, dout_valid}, 32'd0);
        mon_en = 1'b0;
        check("order_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("order_%0d", i), got_q[i], exp_q[i]);
        end

        // Disable, retire the request, then push+pop and flush-during-pop.
        wb_write(4'h8, 32'd0, 1'b0);
        check("req_held_disable", {31'd0, dma_req_o}, 32'd1);
        dma_pulse();
        repeat (3) @(posedge clk);
        #1;
        check("req_stays_low", {31'd0, dma_req_o}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            wb_write(4'h0, 32'h200 + 32'(i), 1'b0);
        end
        wb_read(4'h4, 32'h0000_000C, "status_lvl12");
        wb_write(4'h0, 32'h55, 1'b1);
        dout_ready = 1'b0;
        wb_read(4'h4, 32'h0000_000C, "pushpop_lvl12");
        check("head_after_pop", dout_data, 32'h0000_0201);
        wb_write(4'h8, 32'd4, 1'b1);
        check("flush_valid", {31'd0, dout_valid}, 32'd0);
        dout_ready = 1'b0;
        wb_read(4'h4, 32'h0002_0000, "status_after_flush");

        // Request held across CTRL=0, then dropped by reset.
        wb_write(4'h8, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check("req_up_again", {31'd0, dma_req_o}, 32'd1);
        wb_write(4'h8, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("req_not_withdrawn", {31'd0, dma_req_o}, 32'd1);
        dma_pulse();
        repeat (3) @(posedge clk);
        #1;
        check("req_off_disabled", {31'd0, dma_req_o}, 32'd0);
        wb_write(4'h8, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check("req_before_rst", {31'd0, dma_req_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("req_rst_drop", {31'd0, dma_req_o}, 32'd0);
        #1;
        rst_i = 1'b0;
        wb_read(4'h8, 32'd0, "ctrl_after_rst");
        wb_read(4'h4, 32'h0002_0000, "status_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
